loop_incrementer: RTL
=====================

LOOP_INCREMENTER -- requirements
Module: loop_incrementer

Interface
REQ-001 SHALL have parameter WIDTH, default 3: bit width of each data channel, legal range 1..32.
REQ-002 SHALL have parameter ITERS, default 8: loop iterations per run, legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: run request, sampled only in IDLE.
REQ-006 SHALL have ports a, b, c, input, WIDTH each: initial channel values, captured on an accepted start.
REQ-007 SHALL have port ch_en, input, 3: per-channel increment enable (bit0=a, bit1=b, bit2=c), captured on an accepted start.
REQ-008 SHALL have ports out_a, out_b, out_c, output, WIDTH each: registered channel values.
REQ-009 SHALL have port iter, output, CW = $clog2(ITERS+1): count of completed iterations in the current or last run.
REQ-010 SHALL have port busy, output, 1: high while in RUN.
REQ-011 SHALL have port done, output, 1: single-cycle completion pulse.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at edge k SHALL, at edge k, load out_a/out_b/out_c from a/b/c, latch ch_en, clear iter to 0 and enter RUN.
REQ-014 Each RUN cycle SHALL, at the edge, add 1 to every enabled channel, leave disabled channels unchanged, and increment iter.
REQ-015 RUN SHALL perform exactly ITERS iterations: at the edge where iter goes from ITERS-1 to ITERS, the FSM SHALL enter DONE.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE; DONE SHALL then return to IDLE unconditionally.
REQ-017 Latency SHALL be fixed: done is high exactly ITERS+1 cycles after the start-accept edge, for every WIDTH and ch_en.
REQ-018 start outside IDLE SHALL be ignored; no queuing.
REQ-019 In DONE and IDLE, out_a/out_b/out_c and iter SHALL hold the final run values until the next accepted start.
REQ-020 Changes on a, b, c or ch_en after the accept edge SHALL have no effect on the current run.
REQ-021 Without saturation (REQ-026), addition SHALL wrap modulo 2^WIDTH, e.g. WIDTH=3: 7+1 -> 0.
REQ-022 ch_en=3'b000 SHALL still run the full ITERS cycles; outputs equal the captured inputs.
REQ-023 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and set out_a=out_b=out_c=0, iter=0, busy=0, done=0; rst SHALL take priority over start.
REQ-025 rst asserted mid-RUN or in DONE SHALL abort the run with no done pulse; the first start after rst is released SHALL be accepted normally.

Configuration
REQ-026 With macro LOOP_INCREMENTER_SAT_EN defined, each channel increment SHALL saturate at 2^WIDTH-1; without the macro, channels SHALL wrap per REQ-021; timing and handshake SHALL be identical in both builds.

Verification
REQ-027 WIDTH=3, ITERS=5, a=2, b=5, c=7, ch_en=111, start one cycle -> done ITERS+1=6 cycles after accept; out_a=7, out_b=2, out_c=4; iter=5.
REQ-028 Same stimulus built with LOOP_INCREMENTER_SAT_EN -> out_a=7, out_b=7, out_c=7; done timing unchanged.
REQ-029 WIDTH=3, ITERS=5, ch_en=010, a=1, b=1, c=1 -> out_a=1, out_b=6, out_c=1; start pulsed during RUN -> ignored, exactly one done pulse.
REQ-030 Default parameters (WIDTH=3, ITERS=8), a=3, start -> busy high 8 cycles; done one cycle; out_a=3 (full wrap); iter=8.
REQ-031 rst asserted on the 3rd RUN cycle -> next cycle all outputs 0 and state IDLE, no done pulse; a new start afterwards completes normally.
REQ-032 rst and start both high in IDLE -> reset wins, stays IDLE; start held high on the next cycle -> accepted.

Source files
------------

// File: rtl/loop_incrementer.sv
// loop_incrementer: on an accepted start, captures three WIDTH-bit channels
// and a per-channel enable, then runs exactly ITERS iterations, adding 1 to
// every enabled channel on each iteration. A one-cycle done pulse follows
// the last iteration.
//
// Build option: define LOOP_INCREMENTER_SAT_EN to make each channel saturate
// at 2^WIDTH-1 instead of wrapping. Timing and handshake are identical in
// both builds.
//
// Handshake: start is sampled only while idle (busy=0, done=0). An accepted
// start raises busy on the following cycle. busy stays high for exactly
// ITERS cycles. done is then high for exactly one cycle. A start seen while
// busy or done is dropped, not queued.
//
// fsm_state exposes the controller state for debug: 0=IDLE, 1=RUN, 2=DONE.
module loop_incrementer #(
    parameter  int WIDTH = 3,
    parameter  int ITERS = 8,
    localparam int CW    = $clog2(ITERS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [2:0]       ch_en,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [CW-1:0]    iter,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The iteration whose edge moves the FSM into DONE.
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

    state_t     state;
    logic [2:0] en_q;

    // One iteration's update of one channel; disabled channels are unchanged.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                              input logic en);
`ifdef LOOP_INCREMENTER_SAT_EN
        if (en && (v != {WIDTH{1'b1}}))
            return v + WIDTH'(1);
        return v;
`else
        if (en)
            return v + WIDTH'(1);
        return v;
`endif
    endfunction

    assign fsm_state = state;

    // Controller and datapath: every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out_a <= '0;
            out_b <= '0;
            out_c <= '0;
            iter  <= '0;
            en_q  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        out_a <= a;
                        out_b <= b;
                        out_c <= c;
                        en_q  <= ch_en;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    out_a <= step(out_a, en_q[0]);
                    out_b <= step(out_b, en_q[1]);
                    out_c <= step(out_c, en_q[2]);
                    iter  <= iter + CW'(1);
                    if (iter == LAST_ITER) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Results stay on the outputs; only the pulse ends.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
